rib_arbiter: RTL

- Shared-bus arbiter between the rooth core and the JTAG debug module, in front of the single system bus inside rooth_soc.
- The bus reaches instruction/data memory and the GPIO/UART/SPI peripherals.
- Three masters share the bus: m0 = JTAG debug (absolute priority), m1 = core data port, m2 = core fetch port. m1 and m2 share the bus round-robin.
- Also generates the core pipeline hold and a per-transaction timeout with error return.

---
 rtl/rib_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rib_arbiter.sv
// Three-master system-bus arbiter: JTAG debug (m0) has absolute priority,
// the core data (m1) and fetch (m2) ports share the bus round-robin.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | bus free; s_* quiet; owner selected on the next edge
// ST_GRANT | owner drives the slave; waits for s_ack or the timeout
module rib_arbiter #(
   parameter int CPU_WIDTH   = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 m0_req,
   input  logic                 m0_we,
   input  logic [CPU_WIDTH-1:0] m0_addr,
   input  logic [CPU_WIDTH-1:0] m0_wdata,
   output logic [CPU_WIDTH-1:0] m0_rdata,
   output logic                 m0_ack,
   output logic                 m0_err,
   input  logic                 m1_req,
   input  logic                 m1_we,
   input  logic [CPU_WIDTH-1:0] m1_addr,
   input  logic [CPU_WIDTH-1:0] m1_wdata,
   output logic [CPU_WIDTH-1:0] m1_rdata,
   output logic                 m1_ack,
   output logic                 m1_err,
   input  logic                 m2_req,
   input  logic                 m2_we,
   input  logic [CPU_WIDTH-1:0] m2_addr,
   input  logic [CPU_WIDTH-1:0] m2_wdata,
   output logic [CPU_WIDTH-1:0] m2_rdata,
   output logic                 m2_ack,
   output logic                 m2_err,
   output logic                 s_req,
   output logic                 s_we,
   output logic [CPU_WIDTH-1:0] s_addr,
   output logic [CPU_WIDTH-1:0] s_wdata,
   input  logic [CPU_WIDTH-1:0] s_rdata,
   input  logic                 s_ack,
   output logic                 hold_o,
   output logic [1:0]           owner_o
);

   localparam logic       ST_IDLE  = 1'b0;
   localparam logic       ST_GRANT = 1'b1;
   localparam logic [1:0] OWN_NONE = 2'd3;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

   logic                 state;
   logic [1:0]           owner;
   logic [1:0]           last_core;
   logic [15:0]          tmo_cnt;
   logic [1:0]           sel;
   logic                 tmo_hit;
   logic                 done;
   logic [CPU_WIDTH-1:0] rdata_ret;

   assign tmo_hit   = (state == ST_GRANT) && !s_ack && (tmo_cnt == TMO_LAST);
   assign done      = (state == ST_GRANT) && (s_ack || tmo_hit);
   assign rdata_ret = s_ack ? s_rdata : '0;

   // m0 always wins; a core tie goes to the port that was not served last
   always_comb begin
      sel = OWN_NONE;
      if (m0_req)
         sel = 2'd0;
      else if (m1_req && m2_req)
         sel = (last_core == 2'd1) ? 2'd2 : 2'd1;
      else if (m1_req)
         sel = 2'd1;
      else if (m2_req)
         sel = 2'd2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         owner     <= OWN_NONE;
         last_core <= 2'd2;
         tmo_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               tmo_cnt <= '0;
               if (sel != OWN_NONE) begin
                  state <= ST_GRANT;
                  owner <= sel;
                  if (sel != 2'd0)
                     last_core <= sel;
               end
            end
            default: begin
               if (done) begin
                  state   <= ST_IDLE;
                  owner   <= OWN_NONE;
                  tmo_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   always_comb begin
      s_req   = (state == ST_GRANT);
      s_we    = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      if (state == ST_GRANT) begin
         case (owner)
            2'd0: begin
               s_we    = m0_we;
               s_addr  = m0_addr;
               s_wdata = m0_wdata;
            end
            2'd1: begin
               s_we    = m1_we;
               s_addr  = m1_addr;
               s_wdata = m1_wdata;
            end
            2'd2: begin
               s_we    = m2_we;
               s_addr  = m2_addr;
               s_wdata = m2_wdata;
            end
            default: ;
         endcase
      end
   end

   assign m0_ack   = done && (owner == 2'd0);
   assign m1_ack   = done && (owner == 2'd1);
   assign m2_ack   = done && (owner == 2'd2);
   assign m0_err   = m0_ack && !s_ack;
   assign m1_err   = m1_ack && !s_ack;
   assign m2_err   = m2_ack && !s_ack;
   assign m0_rdata = m0_ack ? rdata_ret : '0;
   assign m1_rdata = m1_ack ? rdata_ret : '0;
   assign m2_rdata = m2_ack ? rdata_ret : '0;

   // gated by rst_n so the core is released the moment reset hits
   assign hold_o  = rst_n & ((m1_req & ~m1_ack) | (m2_req & ~m2_ack));
   assign owner_o = owner;

endmodule
